phy_rx_byte_sync: RTL and testbench

Byte-level receive synchronizer for the physical layer. It sits directly downstream of the receive serial-to-parallel converter and consumes one deserialized byte per clk_4f cycle. It acquires lane alignment from a run of comma (0xBC) bytes and then classifies each byte as comma, idle (0x7C) or payload. Payload is forwarded with a valid strobe and idle is flagged. Sync is dropped if commas stop arriving.

---
 rtl/phy_rx_byte_sync.sv | 154 +++++++++++++++
 tb/tb_phy_rx_byte_sync.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_byte_sync.sv
// ---------------------------------------------------------------------------
// phy_rx_byte_sync
//   Byte-level receive synchronizer. Acquires lane alignment from a run of
//   SYNC_COUNT consecutive comma bytes. Once aligned, it classifies each byte
//   as comma, idle or payload. Sync is dropped after COMMA_TIMEOUT
//   consecutive non-comma bytes.
//
// Ports
//   clk_4f        in   byte clock, rising edge
//   reset         in   synchronous, active-low
//   data_in       in   [7:0] deserialized byte, one per cycle
//   data_out      out  [7:0] last forwarded payload byte (held)
//   valid_out     out  one-cycle strobe: data_out carries a new payload byte
//   idle_out      out  one-cycle strobe: sampled byte was IDLE while synced
//   active_out    out  lane synchronized
//   sync_loss_cnt out  [7:0] saturating count of timeout-induced sync losses
// ---------------------------------------------------------------------------
module phy_rx_byte_sync #(
  parameter int          SYNC_COUNT    = 4,
  parameter int          COMMA_TIMEOUT = 32,
  parameter logic [7:0]  COMMA         = 8'hBC,
  parameter logic [7:0]  IDLE          = 8'h7C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       idle_out,
  output logic       active_out,
  output logic [7:0] sync_loss_cnt
);

  // Comma run counter is at least 3 bits wide; timeout counter fits COMMA_TIMEOUT.
  localparam int BCW = ($clog2(SYNC_COUNT + 1) < 3) ? 3 : $clog2(SYNC_COUNT + 1);
  localparam int TW  = $clog2(COMMA_TIMEOUT + 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(SYNC_COUNT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(COMMA_TIMEOUT);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, SYNCED = 2'd2} state_t;

  state_t         r_state,  w_state_nxt;
  logic [BCW-1:0] r_bc_cnt, w_bc_nxt;
  logic [TW-1:0]  r_tmo_cnt, w_tmo_nxt;
  logic [7:0]     r_data,   w_data_nxt;
  logic           r_valid,  w_valid_nxt;
  logic           r_idle,   w_idle_nxt;
  logic           r_active, w_active_nxt;
  logic [7:0]     r_loss,   w_loss_nxt;

  logic           w_comma;
  logic [BCW-1:0] w_bc_inc;
  logic [TW-1:0]  w_tmo_inc;

  assign w_comma   = (data_in == COMMA);
  assign w_bc_inc  = r_bc_cnt + 1'b1;
  assign w_tmo_inc = r_tmo_cnt + 1'b1;

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      r_state   <= SEARCH;
      r_bc_cnt  <= '0;
      r_tmo_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_idle    <= 1'b0;
      r_active  <= 1'b0;
      r_loss    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bc_cnt  <= w_bc_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_idle    <= w_idle_nxt;
      r_active  <= w_active_nxt;
      r_loss    <= w_loss_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bc_nxt     = r_bc_cnt;
    w_tmo_nxt    = r_tmo_cnt;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_idle_nxt   = 1'b0;
    w_active_nxt = r_active;
    w_loss_nxt   = r_loss;

    case (r_state)
      SEARCH: begin
        if (w_comma) begin
          w_state_nxt = CHECK;
          w_bc_nxt    = BCW'(1);
        end else begin
          w_bc_nxt    = '0;
        end
      end

      CHECK: begin
        if (w_comma) begin
          if (w_bc_inc == BC_LAST) begin
            w_state_nxt  = SYNCED;
            w_active_nxt = 1'b1;
            w_tmo_nxt    = '0;
            w_bc_nxt     = '0;
          end else begin
            w_bc_nxt     = w_bc_inc;
          end
        end else begin
          // Broken run: the byte is dropped and acquisition restarts.
          w_state_nxt = SEARCH;
          w_bc_nxt    = '0;
        end
      end

      SYNCED: begin
        if (w_comma) begin
          w_tmo_nxt = '0;
        end else if (w_tmo_inc == TMO_LAST) begin
          // Timeout byte is discarded; no strobe on the losing edge.
          w_state_nxt  = SEARCH;
          w_active_nxt = 1'b0;
          w_bc_nxt     = '0;
          w_tmo_nxt    = '0;
          if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
        end else begin
          w_tmo_nxt = w_tmo_inc;
          if (data_in == IDLE) begin
            w_idle_nxt  = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = data_in;
          end
        end
      end

      default: begin
        w_state_nxt  = SEARCH;
        w_bc_nxt     = '0;
        w_tmo_nxt    = '0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign idle_out      = r_idle;
  assign active_out    = r_active;
  assign sync_loss_cnt = r_loss;

endmodule

// File: tb/tb_phy_rx_byte_sync.sv
// ---------------------------------------------------------------------------
// tb_phy_rx_byte_sync
//   Directed sequences plus randomized byte streams against a reference model
//   that tracks comma run length, non-comma gap length and loss count as
//   plain integers.
// ---------------------------------------------------------------------------
module tb_phy_rx_byte_sync;
  localparam int SYNC_COUNT    = 4;
  localparam int COMMA_TIMEOUT = 32;
  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] ID = 8'h7C;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out, sync_loss_cnt;
  logic       valid_out, idle_out, active_out;

  phy_rx_byte_sync #(.SYNC_COUNT(SYNC_COUNT), .COMMA_TIMEOUT(COMMA_TIMEOUT),
                     .COMMA(BC), .IDLE(ID)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .data_out(data_out),
    .valid_out(valid_out), .idle_out(idle_out), .active_out(active_out),
    .sync_loss_cnt(sync_loss_cnt));

  always #5 clk_4f = ~clk_4f;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int   m_run, m_gap, m_loss;
  bit   m_sync, m_valid, m_idle;
  logic [7:0] m_data;

  // Directed-check bookkeeping
  int n_valid_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_gap = 0; m_loss = 0; m_sync = 0;
    m_valid = 0; m_idle = 0; m_data = 8'h00;
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_valid = 0; m_idle = 0;
    if (!m_sync) begin
      if (b == BC) begin
        m_run++;
        if (m_run == SYNC_COUNT) begin m_sync = 1; m_gap = 0; m_run = 0; end
      end else m_run = 0;
    end else if (b == BC) begin
      m_gap = 0;
    end else begin
      m_gap++;
      if (m_gap == COMMA_TIMEOUT) begin
        m_sync = 0; m_run = 0; m_gap = 0;
        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
      end else if (b == ID) m_idle = 1;
      else begin m_valid = 1; m_data = b; end
    end
  endtask

  task automatic check_all();
    chk("data_out",   32'(data_out),      32'(m_data));
    chk("valid_out",  32'(valid_out),     32'(m_valid));
    chk("idle_out",   32'(idle_out),      32'(m_idle));
    chk("active_out", 32'(active_out),    32'(m_sync));
    chk("loss_cnt",   32'(sync_loss_cnt), 32'(m_loss));
  endtask

  // Apply one byte: drive at negedge, DUT samples at posedge, check at next negedge.
  task automatic step(input logic [7:0] b);
    data_in = b;
    @(posedge clk_4f);
    m_byte(b);
    @(negedge clk_4f);
    check_all();
    if (valid_out) n_valid_seen++;
  endtask

  task automatic do_reset(input logic [7:0] b);
    reset = 1'b0; data_in = b;
    @(posedge clk_4f);
    m_reset();
    @(negedge clk_4f);
    check_all();
    reset = 1'b1;
  endtask

  task automatic commas(input int n);
    for (int i = 0; i < n; i++) step(BC);
  endtask

  initial begin
    m_reset();
    @(negedge clk_4f);
    do_reset(8'hBC);
    do_reset(8'h00);

    // Basic acquisition then payload / idle / payload
    commas(3);
    chk("pre_sync_active", 32'(active_out), 32'd0);
    step(BC);
    chk("sync_after_4bc", 32'(active_out), 32'd1);
    step(8'h55); chk("first_payload", {valid_out, data_out}, {1'b1, 8'h55});
    step(ID);    chk("idle_strobe", {idle_out, valid_out}, 2'b10);
    step(8'hA3); chk("second_payload", {valid_out, data_out}, {1'b1, 8'hA3});

    // Broken comma run
    do_reset(8'h00);
    commas(3); step(8'h11);
    chk("broken_run", {active_out, valid_out, data_out}, 10'h000);
    commas(4);
    chk("reacq", 32'(active_out), 32'd1);
    step(8'h22); chk("after_reacq", {valid_out, data_out}, {1'b1, 8'h22});

    // Timeout at the 32nd non-comma byte
    commas(1);
    for (int i = 1; i <= 32; i++) step(8'(i));
    chk("tmo_active", 32'(active_out), 32'd0);
    chk("tmo_loss",   32'(sync_loss_cnt), 32'd1);
    chk("tmo_hold",   {valid_out, data_out}, {1'b0, 8'h1F});

    // Comma in the middle keeps sync
    do_reset(8'h00);
    commas(4);
    n_valid_seen = 0;
    for (int i = 0; i < 20; i++) step(8'h30 + 8'(i));
    step(BC);
    for (int i = 0; i < 20; i++) step(8'h50 + 8'(i));
    chk("mid_comma_valids", 32'(n_valid_seen), 32'd40);
    chk("mid_comma_active", 32'(active_out), 32'd1);
    chk("mid_comma_loss",   32'(sync_loss_cnt), 32'd0);

    // Reset mid-operation with loss count 3
    for (int k = 0; k < 3; k++) begin
      commas(4);
      for (int i = 0; i < 32; i++) step(8'h01);
    end
    commas(4);
    chk("loss3", 32'(sync_loss_cnt), 32'd3);
    do_reset(BC);
    chk("rst_all_zero", {data_out, valid_out, idle_out, active_out, sync_loss_cnt}, 19'h0);
    commas(3); step(8'h44);
    chk("rst_no_sync", 32'(active_out), 32'd0);
    commas(4);
    chk("rst_reacq", 32'(active_out), 32'd1);

    // Saturation of sync_loss_cnt
    do_reset(8'h00);
    for (int k = 0; k < 260; k++) begin
      commas(4);
      for (int i = 0; i < 32; i++) step(8'h01 + 8'(i));
    end
    chk("loss_sat", 32'(sync_loss_cnt), 32'd255);

    // Randomized streams, with occasional long non-comma bursts
    do_reset(8'h00);
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 3) == 0) begin
        int len = $urandom_range(25, 40);
        for (int i = 0; i < len; i++) begin
          logic [7:0] b = 8'($urandom);
          if (b == BC) b = 8'h00;
          if ($urandom_range(0, 4) == 0) b = ID;
          step(b);
        end
      end else begin
        for (int i = 0; i < 40; i++) begin
          int r = $urandom_range(0, 99);
          logic [7:0] b;
          if (r < 35)      b = BC;
          else if (r < 50) b = ID;
          else             b = 8'($urandom);
          step(b);
        end
      end
      if ($urandom_range(0, 19) == 0) do_reset(8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
